// File: rtl/exp_freq_mult_fifo_if.sv
// Bundle of the request, result and FIFO status signals for exp_freq_mult_fifo.
// The master side issues requests and pops results. The slave side is the engine.
interface exp_freq_mult_fifo_if #(
    parameter int FRAC_W  = 16,
    parameter int SHIFT_W = 2,
    parameter int DEPTH   = 4
);
    localparam int QW = FRAC_W + 2 + (2 ** SHIFT_W - 1);
    localparam int UW = $clog2(DEPTH) + 1;

    logic              start;
    logic [FRAC_W-1:0] vi;
    logic [SHIFT_W-1:0] ui;
    logic              rd_req;
    logic [QW-1:0]     q;
    logic              full;
    logic              empty;
    logic [UW-1:0]     usedw;
    logic              busy;
    logic              done;

    modport master (
        output start, vi, ui, rd_req,
        input  q, full, empty, usedw, busy, done
    );

    modport slave (
        input  start, vi, ui, rd_req,
        output q, full, empty, usedw, busy, done
    );
endinterface

// File: rtl/exp_freq_mult_fifo.sv
// Exponential frequency-multiplier engine.
// It evaluates a truncated Taylor series of e^x iteratively, scales the result
// by 2^ui and queues it in a show-ahead circular FIFO.
module exp_freq_mult_fifo #(
    parameter int FRAC_W  = 16,
    parameter int TERMS   = 8,
    parameter int SHIFT_W = 2,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    exp_freq_mult_fifo_if.slave  bus
);
    localparam int TW  = FRAC_W + 2;
    localparam int QW  = FRAC_W + 2 + (2 ** SHIFT_W - 1);
    localparam int EXT = QW - TW;
    localparam int RW  = FRAC_W + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int UW  = AW + 1;
    localparam int KW  = $clog2(TERMS);
    localparam int P1W = TW + FRAC_W;
    localparam int P2W = TW + RW;

    localparam logic [TW-1:0] TERM_ONE = TW'(1) << FRAC_W;
    localparam logic [QW-1:0] ACC_ONE  = QW'(1) << FRAC_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        SHIFT,
        PUSH
    } state_t;

    state_t state_q, state_d;

    logic [FRAC_W-1:0]  x_q, x_d;
    logic [SHIFT_W-1:0] sh_q, sh_d;
    logic [KW-1:0]      k_q, k_d;
    logic [TW-1:0]      term_q, term_d;
    logic [QW-1:0]      acc_q, acc_d;

    logic [QW-1:0]      mem_q [DEPTH];
    logic [QW-1:0]      mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]      usedw_q, usedw_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               wr_en;
    logic               rd_en;
    logic               last_term;

    logic [RW-1:0]      rom [TERMS];
    logic [P1W-1:0]     prod1;
    logic [TW-1:0]      p_trunc;
    logic [P2W-1:0]     prod2;
    logic [TW-1:0]      term_new;

    // Reciprocal table r_k = floor(2^FRAC_W / k); entry 0 is never addressed.
    assign rom[0] = '0;
    for (genvar i = 1; i < TERMS; i++) begin : g_rom
        assign rom[i] = RW'((64'd1 << FRAC_W) / 64'(i));
    end

    // One series step: multiply by x, then divide by k through the reciprocal ROM.
    assign prod1     = {{FRAC_W{1'b0}}, term_q} * {{TW{1'b0}}, x_q};
    assign p_trunc   = TW'(prod1 >> FRAC_W);
    assign prod2     = {{RW{1'b0}}, p_trunc} * {{TW{1'b0}}, rom[k_q]};
    assign term_new  = TW'(prod2 >> FRAC_W);
    assign last_term = (k_q == KW'(TERMS - 1));

    assign fifo_full  = (usedw_q == UW'(DEPTH));
    assign fifo_empty = (usedw_q == '0);
    assign rd_en      = bus.rd_req && !fifo_empty;

    // FSM state register, returning to IDLE on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: capture, initialise, iterate terms, scale, then wait for FIFO room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = MUL;
            MUL:     if (last_term) state_d = (sh_q != '0) ? SHIFT : PUSH;
            SHIFT:   if (sh_q == SHIFT_W'(1)) state_d = PUSH;
            PUSH:    if (wr_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: a push can complete into a full FIFO only when a pop frees a slot.
    always_comb begin
        wr_en    = (state_q == PUSH) && (!fifo_full || bus.rd_req);
        bus.done = wr_en;
        bus.busy = (state_q != IDLE);
    end

    // Datapath next values for the operand, shift count, term index, term and accumulator.
    always_comb begin
        x_d    = x_q;
        sh_d   = sh_q;
        k_d    = k_q;
        term_d = term_q;
        acc_d  = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d  = bus.vi;
                    sh_d = bus.ui;
                end
            end
            LOAD: begin
                acc_d  = ACC_ONE;
                term_d = TERM_ONE;
                k_d    = KW'(1);
            end
            MUL: begin
                term_d = term_new;
                acc_d  = acc_q + {{EXT{1'b0}}, term_new};
                k_d    = k_q + KW'(1);
            end
            SHIFT: begin
                acc_d = acc_q << 1;
                sh_d  = sh_q - SHIFT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // FIFO next values: pointers wrap modulo DEPTH, and a simultaneous push and pop keep the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = acc_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   usedw_d = usedw_q + UW'(1);
            2'b01:   usedw_d = usedw_q - UW'(1);
            default: usedw_d = usedw_q;
        endcase
    end

    // Datapath and FIFO registers. Reset clears everything, so an in-flight result is discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q      <= '0;
            sh_q     <= '0;
            k_q      <= '0;
            term_q   <= '0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            x_q      <= x_d;
            sh_q     <= sh_d;
            k_q      <= k_d;
            term_q   <= term_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            mem_q    <= mem_d;
        end
    end

    // Show-ahead head and status, taken from registered FIFO state only.
    always_comb begin
        bus.q     = fifo_empty ? '0 : mem_q[rd_ptr_q];
        bus.full  = fifo_full;
        bus.empty = fifo_empty;
        bus.usedw = usedw_q;
    end
endmodule
